// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
//   ADDR_W / DATA_W : address and data widths
//   F3_*            : RV32I load/store funct3 encodings
//   mem_state_t     : responder FSM states
//   mem_req_t       : latched request payload
package mem_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic              we;
      logic [2:0]        funct3;
      logic [ADDR_W-1:0] adrs;
      logic [DATA_W-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// M-stage data-memory port between datapath (master) and responder (slave).
//   mem_req, mem_we, funct3, memAdrs, memDataWD : request from datapath
//   memDataRD, stall_mem, mem_fault             : response to datapath
interface data_mem_responder_if;
   import mem_pkg::*;

   logic              mem_req;
   logic              mem_we;
   logic [2:0]        funct3;
   logic [ADDR_W-1:0] memAdrs;
   logic [DATA_W-1:0] memDataWD;
   logic [DATA_W-1:0] memDataRD;
   logic              stall_mem;
   logic              mem_fault;

   modport master (
      output mem_req, mem_we, funct3, memAdrs, memDataWD,
      input  memDataRD, stall_mem, mem_fault
   );

   modport slave (
      input  mem_req, mem_we, funct3, memAdrs, memDataWD,
      output memDataRD, stall_mem, mem_fault
   );

endinterface

// File: rtl/load_extend.sv
// Selects the byte/halfword of a loaded word and sign- or zero-extends it.
//   word_i   : full 32-bit word read from memory
//   addr_i   : byte offset within the word
//   funct3_i : RV32I load funct3
//   ext_o    : extended result (0 for non-load encodings)
module load_extend
   import mem_pkg::*;
(
   input  logic [DATA_W-1:0] word_i,
   input  logic [1:0]        addr_i,
   input  logic [2:0]        funct3_i,
   output logic [DATA_W-1:0] ext_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Lane select then extension by funct3
   always_comb begin
      byte_sel = 8'(word_i >> {addr_i, 3'b000});
      half_sel = 16'(word_i >> {addr_i[1], 4'b0000});
      ext_o    = '0;
      case (funct3_i)
         F3_B:    ext_o = {{24{byte_sel[7]}}, byte_sel};
         F3_H:    ext_o = {{16{half_sel[15]}}, half_sel};
         F3_W:    ext_o = word_i;
         F3_BU:   ext_o = {24'd0, byte_sel};
         F3_HU:   ext_o = {16'd0, half_sel};
         default: ext_o = '0;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for the datapath's M-stage data-memory port with an internal
// byte-writable word RAM, configurable wait states and access fault detection.
//   clk   : clock
//   reset : synchronous active-low reset (RAM contents are kept)
//   bus   : slave side of the memory port (request in, data/stall/fault out)
module data_mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned       DEPTH_WORDS = 1024,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned       WAIT_STATES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   data_mem_responder_if.slave  bus
);

   localparam int unsigned   IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned   CNT_W = 3;
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH_WORDS) << 2;

   mem_state_t         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   mem_req_t           req_q, req_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;
   logic               fault_q, fault_d;

   logic [DATA_W-1:0]  ram_q [DEPTH_WORDS];

   mem_req_t           acc;
   logic [ADDR_W-1:0]  off;
   logic [IDX_W-1:0]   idx;
   logic               f3_ok;
   logic               misal;
   logic               oor;
   logic               bad;
   logic [3:0]         be;
   logic [DATA_W-1:0]  wrep;
   logic [DATA_W-1:0]  ext;
   logic               access_en;
   logic               ram_we;

   // With zero wait states the access happens on the accepting edge, so it
   // must use the live inputs; otherwise it uses the latched copy.
   always_comb begin
      if (state_q == ST_IDLE) begin
         acc.we     = bus.mem_we;
         acc.funct3 = bus.funct3;
         acc.adrs   = bus.memAdrs;
         acc.wdata  = bus.memDataWD;
      end else begin
         acc = req_q;
      end
   end

   // Fault decode and lane steering for the access being performed
   always_comb begin
      off = acc.adrs - BASE_ADDR;
      idx = off[IDX_W+1:2];
      oor = {1'b0, off} >= SPAN;

      case (acc.funct3)
         F3_B, F3_H, F3_W: f3_ok = 1'b1;
         F3_BU, F3_HU:     f3_ok = ~acc.we;
         default:          f3_ok = 1'b0;
      endcase

      case (acc.funct3[1:0])
         2'b01:   misal = acc.adrs[0];
         2'b10:   misal = |acc.adrs[1:0];
         default: misal = 1'b0;
      endcase

      bad = ~f3_ok | misal | oor;

      case (acc.funct3[1:0])
         2'b00: begin
            be   = 4'b0001 << acc.adrs[1:0];
            wrep = {4{acc.wdata[7:0]}};
         end
         2'b01: begin
            be   = 4'b0011 << {acc.adrs[1], 1'b0};
            wrep = {2{acc.wdata[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wrep = acc.wdata;
         end
      endcase
   end

   load_extend u_load_extend (
      .word_i   (ram_q[idx]),
      .addr_i   (acc.adrs[1:0]),
      .funct3_i (acc.funct3),
      .ext_o    (ext)
   );

   // Next-state and result logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      rdata_d   = rdata_q;
      fault_d   = fault_q;
      access_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            rdata_d = '0;
            fault_d = 1'b0;
            if (bus.mem_req) begin
               req_d = acc;
               cnt_d = CNT_W'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  access_en = 1'b1;
                  state_d   = ST_DONE;
               end else begin
                  state_d = ST_BUSY;
               end
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_d == '0) begin
               access_en = 1'b1;
               state_d   = ST_DONE;
            end
         end
         ST_DONE: begin
            rdata_d = '0;
            fault_d = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (access_en) begin
         fault_d = bad;
         rdata_d = (~bad & ~acc.we) ? ext : '0;
      end
   end

   // Reset blocks the write even on the edge that would have committed it
   assign ram_we = access_en & acc.we & ~bad & reset;

   // State and request/result registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         rdata_q <= rdata_d;
         fault_q <= fault_d;
      end
   end

   // Byte-enabled RAM write; contents survive reset
   always_ff @(posedge clk) begin
      if (ram_we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) ram_q[idx][8*b +: 8] <= wrep[8*b +: 8];
         end
      end
   end

   assign bus.memDataRD = rdata_q;
   assign bus.mem_fault = fault_q;
   assign bus.stall_mem = bus.mem_req & (state_q != ST_DONE);

endmodule
